// File: rtl/regfile_pkg.sv
// Shared mode encodings, bank enumeration and physical register layout for banked_regfile.
package regfile_pkg;

    localparam int NUM_PHYS = 33;
    localparam int PHYS_W   = 6;

    localparam logic [3:0] M_USR = 4'b0000;
    localparam logic [3:0] M_FIQ = 4'b0001;
    localparam logic [3:0] M_IRQ = 4'b0010;
    localparam logic [3:0] M_SVC = 4'b0011;
    localparam logic [3:0] M_MON = 4'b0110;
    localparam logic [3:0] M_ABT = 4'b0111;
    localparam logic [3:0] M_HYP = 4'b1010;
    localparam logic [3:0] M_UND = 4'b1011;
    localparam logic [3:0] M_SYS = 4'b1111;

    typedef enum logic [3:0] {
        BANK_USR,
        BANK_FIQ,
        BANK_IRQ,
        BANK_SVC,
        BANK_MON,
        BANK_ABT,
        BANK_UND,
        BANK_HYP,
        BANK_ILL
    } bank_e;

    // Physical layout: usr r0-r14, fiq r8-r14, r13/r14 pairs, hyp r13.
    localparam logic [PHYS_W-1:0] PHYS_USR = 6'd0;
    localparam logic [PHYS_W-1:0] PHYS_FIQ = 6'd15;
    localparam logic [PHYS_W-1:0] PHYS_IRQ = 6'd22;
    localparam logic [PHYS_W-1:0] PHYS_SVC = 6'd24;
    localparam logic [PHYS_W-1:0] PHYS_MON = 6'd26;
    localparam logic [PHYS_W-1:0] PHYS_ABT = 6'd28;
    localparam logic [PHYS_W-1:0] PHYS_UND = 6'd30;
    localparam logic [PHYS_W-1:0] PHYS_HYP = 6'd32;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_e;

    function automatic bank_e mode_to_bank(input logic [4:0] mode);
        bank_e b;
        if (!mode[4]) begin
            b = BANK_ILL;
        end else begin
            case (mode[3:0])
                M_USR, M_SYS: b = BANK_USR;
                M_FIQ:        b = BANK_FIQ;
                M_IRQ:        b = BANK_IRQ;
                M_SVC:        b = BANK_SVC;
                M_MON:        b = BANK_MON;
                M_ABT:        b = BANK_ABT;
                M_HYP:        b = BANK_HYP;
                M_UND:        b = BANK_UND;
                default:      b = BANK_ILL;
            endcase
        end
        return b;
    endfunction

    function automatic logic [PHYS_W-1:0] bank_first(input bank_e b);
        logic [PHYS_W-1:0] idx;
        case (b)
            BANK_FIQ: idx = PHYS_FIQ;
            BANK_IRQ: idx = PHYS_IRQ;
            BANK_SVC: idx = PHYS_SVC;
            BANK_MON: idx = PHYS_MON;
            BANK_ABT: idx = PHYS_ABT;
            BANK_UND: idx = PHYS_UND;
            BANK_HYP: idx = PHYS_HYP;
            default:  idx = PHYS_USR;
        endcase
        return idx;
    endfunction

    function automatic logic [PHYS_W-1:0] bank_last(input bank_e b);
        logic [PHYS_W-1:0] idx;
        case (b)
            BANK_USR: idx = PHYS_USR + 6'd14;
            BANK_FIQ: idx = PHYS_FIQ + 6'd6;
            BANK_IRQ: idx = PHYS_IRQ + 6'd1;
            BANK_SVC: idx = PHYS_SVC + 6'd1;
            BANK_MON: idx = PHYS_MON + 6'd1;
            BANK_ABT: idx = PHYS_ABT + 6'd1;
            BANK_UND: idx = PHYS_UND + 6'd1;
            BANK_HYP: idx = PHYS_HYP;
            default:  idx = PHYS_USR;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/regfile_bank_map.sv
// Resolves an architectural register address under a processor mode to a physical index.
module regfile_bank_map
    import regfile_pkg::*;
#(
    parameter bit IS_WRITE = 1'b0
) (
    input  logic [4:0]        mode,
    input  logic [3:0]        addr,
    output logic [PHYS_W-1:0] phys,
    output logic              is_pc,
    output logic              fault
);

    bank_e bank;
    logic  banked_hi;

    assign bank      = mode_to_bank(mode);
    assign is_pc     = (addr == 4'd15);
    assign banked_hi = (addr >= 4'd8) && !is_pc;

    always_comb begin
        phys  = {2'b00, addr};
        fault = 1'b0;
        case (bank)
            BANK_FIQ: begin
                if (banked_hi) phys = PHYS_FIQ + {2'b00, addr - 4'd8};
            end
            BANK_IRQ, BANK_SVC, BANK_MON, BANK_ABT, BANK_UND: begin
                if (addr == 4'd13 || addr == 4'd14)
                    phys = bank_first(bank) + {{(PHYS_W-1){1'b0}}, (addr == 4'd14)};
            end
            BANK_HYP: begin
                if (addr == 4'd13) phys = PHYS_HYP;
                // hyp owns no r14; the usr copy is not reachable from this mode
                if (addr == 4'd14) begin
                    phys  = PHYS_USR;
                    fault = 1'b1;
                end
            end
            BANK_ILL: begin
                fault = IS_WRITE ? 1'b1 : banked_hi;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/banked_regfile.sv
// Mode-banked register file with registered read ports and a sequential bank-clear engine.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module banked_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               mode,
    input  logic [NUM_RD*4-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pc_wr,
    input  logic [DATA_W-1:0]        pc_data,
    input  logic                     clr_req,
    input  logic [4:0]               clr_mode,
    output logic                     ready,
    output logic                     err_wr,
    output logic                     err_rd,
    input  logic                     err_clr
);

    logic [DATA_W-1:0] regs [NUM_PHYS];
    logic [DATA_W-1:0] pc;

    clr_state_e        state, state_nxt;
    logic [PHYS_W-1:0] clr_idx, clr_idx_nxt;
    logic [PHYS_W-1:0] clr_last, clr_last_nxt;
    logic              clr_we;
    bank_e             clr_bank;
    logic              clr_err_p0;

    logic [PHYS_W-1:0] wr_phys_p0;
    logic              wr_is_pc_p0;
    logic              wr_fault_p0;
    logic              wr_ok_p0;
    logic              wr_err_p0;

    logic [NUM_RD*DATA_W-1:0] rd_val_p0;
    logic [NUM_RD-1:0]        rd_fault_p0;
    logic [NUM_RD*DATA_W-1:0] rd_data_p1;

    assign ready    = (state == ST_IDLE);
    assign clr_bank = mode_to_bank(clr_mode);

    regfile_bank_map #(.IS_WRITE(1'b1)) u_wr_map (
        .mode  (mode),
        .addr  (wr_addr),
        .phys  (wr_phys_p0),
        .is_pc (wr_is_pc_p0),
        .fault (wr_fault_p0)
    );

    // Writes to r15 go through pc_wr only; a general write there is a violation.
    assign wr_ok_p0   = wr_en && ready && !wr_fault_p0 && !wr_is_pc_p0;
    assign wr_err_p0  = wr_en && ready && (wr_fault_p0 || wr_is_pc_p0);
    assign clr_err_p0 = clr_req && (state == ST_IDLE) && (clr_bank == BANK_ILL);

    always_comb begin
        state_nxt    = state;
        clr_idx_nxt  = clr_idx;
        clr_last_nxt = clr_last;
        clr_we       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_req && clr_bank != BANK_ILL) begin
                    state_nxt    = ST_CLEAR;
                    clr_idx_nxt  = bank_first(clr_bank);
                    clr_last_nxt = bank_last(clr_bank);
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == clr_last) state_nxt   = ST_IDLE;
                else                     clr_idx_nxt = clr_idx + 6'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clr_idx  <= '0;
            clr_last <= '0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_idx_nxt;
            clr_last <= clr_last_nxt;
        end
    end

    // Clear and general write are mutually exclusive: writes need ready, clears run only when it is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
            pc <= '0;
        end else begin
            if (clr_we)   regs[clr_idx]    <= '0;
            if (wr_ok_p0) regs[wr_phys_p0] <= wr_data;
            if (pc_wr)    pc               <= pc_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [PHYS_W-1:0] phys_p0;
        logic              is_pc_p0;
        logic              fault_p0;
        logic [DATA_W-1:0] val_p0;

        regfile_bank_map #(.IS_WRITE(1'b0)) u_rd_map (
            .mode  (mode),
            .addr  (rd_addr[4*k +: 4]),
            .phys  (phys_p0),
            .is_pc (is_pc_p0),
            .fault (fault_p0)
        );

        always_comb begin
            val_p0 = is_pc_p0 ? pc : regs[phys_p0];
`ifdef REGFILE_BYPASS_EN
            if (is_pc_p0 && pc_wr)
                val_p0 = pc_data;
            else if (!is_pc_p0 && wr_ok_p0 && (wr_phys_p0 == phys_p0))
                val_p0 = wr_data;
`endif
            if (fault_p0) val_p0 = '0;
        end

        assign rd_val_p0[k*DATA_W +: DATA_W] = val_p0;
        assign rd_fault_p0[k]                = fault_p0;
    end

    // ---- stage p0 -> p1: registered read data ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_p1 <= '0;
        else        rd_data_p1 <= rd_val_p0;
    end

    assign rd_data = rd_data_p1;

    // A same-cycle set wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wr <= 1'b0;
            err_rd <= 1'b0;
        end else begin
            if (wr_err_p0 || clr_err_p0) err_wr <= 1'b1;
            else if (err_clr)            err_wr <= 1'b0;
            if (|rd_fault_p0)            err_rd <= 1'b1;
            else if (err_clr)            err_rd <= 1'b0;
        end
    end

endmodule
